// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and controller state type for the alu_seq block.
// The multiplier-related items matter only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  localparam logic [3:0] OP_SHL   = 4'h0;
  localparam logic [3:0] OP_SHR   = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_IOR   = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_ZTEST = 4'h7;
  localparam logic [3:0] OP_PCZ   = 4'h8;
  localparam logic [3:0] OP_PCZB  = 4'h9;
  localparam logic [3:0] OP_NOP   = 4'hA;
  localparam logic [3:0] OP_ADDC  = 4'hB;
  localparam logic [3:0] OP_SUBB  = 4'hC;
  localparam logic [3:0] OP_MUL   = 4'hD;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per clock,
// done is combinational in the last iteration cycle so product loads on that edge.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               running;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;

  assign acc_next = acc + (b_sh[0] ? a_sh : '0);
  assign done     = running && (cnt == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      a_sh    <= {{WIDTH{1'b0}}, a};
      b_sh    <= b;
    end else if (running) begin
      acc  <= acc_next;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with held result/flag registers and a valid/ready output stage.
// Define ALU_SEQ_MUL_EN to add the multi-cycle MUL (op D); otherwise op D is a NOP.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int SKIP_RESULT_MEM = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] mem,
  input  logic [WIDTH-1:0] wreg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             pc_skip,
  output logic             busy
);

  // Handshake: an operation is taken on a rising edge where in_valid && in_ready;
  // a result is handed over on a rising edge where out_valid && out_ready.

  logic               accept;
  logic               is_mul;
  logic               load_single;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               idle;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_z;
  logic               alu_skip;
  logic               upd_z;
  logic [WIDTH:0]     sum;

  logic [WIDTH-1:0]   result_q;
  logic               carry_q;
  logic               zero_q;
  logic               skip_q;
  logic               out_valid_q;

  assign in_ready    = idle && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign load_single = accept && !is_mul;

`ifdef ALU_SEQ_MUL_EN
  state_t state_q;
  state_t state_n;

  assign is_mul = (op == OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:     if (accept && is_mul) state_n = MUL_BUSY;
      MUL_BUSY: if (mul_done)         state_n = IDLE;
      default:                        state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == MUL_BUSY);
    idle = (state_q == IDLE);
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (mem),
    .b       (wreg),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign busy        = 1'b0;
  assign idle        = 1'b1;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Unlisted opcodes (and op D here) fall through as NOP: result = wreg, flags held.
  always_comb begin
    alu_res  = wreg;
    alu_c    = carry_q;
    alu_z    = zero_q;
    alu_skip = 1'b0;
    upd_z    = 1'b0;
    sum      = '0;
    case (op)
      OP_SHL: begin
        alu_res = {mem[WIDTH-2:0], 1'b0};
        alu_c   = mem[WIDTH-1];
        upd_z   = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, mem[WIDTH-1:1]};
        alu_c   = mem[0];
        upd_z   = 1'b1;
      end
      OP_ADD, OP_ADDC: begin
        sum     = {1'b0, mem} + {1'b0, wreg}
                + {{WIDTH{1'b0}}, (op == OP_ADDC) && carry_q};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        upd_z   = 1'b1;
      end
      OP_SUB, OP_SUBB: begin
        // Bit WIDTH of the extended difference is the borrow; carry means no borrow.
        sum     = {1'b0, mem} - {1'b0, wreg}
                - {{WIDTH{1'b0}}, (op == OP_SUBB) && !carry_q};
        alu_res = sum[WIDTH-1:0];
        alu_c   = ~sum[WIDTH];
        upd_z   = 1'b1;
      end
      OP_AND:   begin alu_res = mem & wreg; upd_z = 1'b1; end
      OP_IOR:   begin alu_res = mem | wreg; upd_z = 1'b1; end
      OP_XOR:   begin alu_res = mem ^ wreg; upd_z = 1'b1; end
      OP_ZTEST: begin alu_res = mem;        upd_z = 1'b1; end
      OP_PCZ: begin
        alu_res  = (SKIP_RESULT_MEM != 0) ? mem : '0;
        alu_skip = |mem;
      end
      OP_PCZB: begin
        alu_res  = (SKIP_RESULT_MEM != 0) ? mem : '0;
        alu_skip = ~|mem;
      end
      OP_NOP, OP_MUL: ;
      default: ;
    endcase
    if (upd_z) alu_z = (alu_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      skip_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load_single) begin
      result_q    <= alu_res;
      carry_q     <= alu_c;
      zero_q      <= alu_z;
      skip_q      <= alu_skip;
      out_valid_q <= 1'b1;
    end else if (mul_done) begin
      result_q    <= mul_product[WIDTH-1:0];
      carry_q     <= |mul_product[2*WIDTH-1:WIDTH];
      zero_q      <= (mul_product[WIDTH-1:0] == '0);
      skip_q      <= 1'b0;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign pc_skip   = skip_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=16) with hand-computed expectations.
// Covers the MUL path when ALU_SEQ_MUL_EN is defined, the op-D-as-NOP path otherwise.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [15:0] mem = '0;
  logic [15:0] wreg = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic        pc_skip;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(16), .SKIP_RESULT_MEM(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .mem       (mem),
    .wreg      (wreg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .pc_skip   (pc_skip),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one op at the falling edge; returns #1 after the accepting edge.
  task automatic issue(input string tag, input logic [3:0] o, input logic [15:0] m,
                       input logic [15:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    mem = m;
    wreg = w;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic c,
                         input logic z, input logic s);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(r));
    chk({tag, "_carry"}, 32'(carry), 32'(c));
    chk({tag, "_zero"}, 32'(zero), 32'(z));
    chk({tag, "_skip"}, 32'(pc_skip), 32'(s));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_carry"}, 32'(carry), 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd0);
    chk({tag, "_skip"}, 32'(pc_skip), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic with carry chaining
    issue("add", 4'h2, 16'h0001, 16'hFFFF);
    chk_out("add", 16'h0000, 1'b1, 1'b1, 1'b0);
    issue("addc", 4'hB, 16'h0002, 16'h0003);
    chk_out("addc", 16'h0006, 1'b0, 1'b0, 1'b0);
    issue("sub_eq", 4'h3, 16'h8001, 16'h8001);
    chk_out("sub_eq", 16'h0000, 1'b1, 1'b1, 1'b0);
    issue("sub_neg", 4'h3, 16'h0001, 16'h0002);
    chk_out("sub_neg", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    issue("subb", 4'hC, 16'h0005, 16'h0001);
    chk_out("subb", 16'h0003, 1'b1, 1'b0, 1'b0);

    // Shifts and logic ops (logic ops hold carry=1 from shifts)
    issue("shl", 4'h0, 16'h8001, 16'h0000);
    chk_out("shl", 16'h0002, 1'b1, 1'b0, 1'b0);
    issue("shr", 4'h1, 16'h0001, 16'h0000);
    chk_out("shr", 16'h0000, 1'b1, 1'b1, 1'b0);
    issue("and", 4'h4, 16'hF0F0, 16'h0F0F);
    chk_out("and", 16'h0000, 1'b1, 1'b1, 1'b0);
    issue("xor", 4'h6, 16'hFF00, 16'h0F0F);
    chk_out("xor", 16'hF00F, 1'b1, 1'b0, 1'b0);
    issue("ior", 4'h5, 16'h1200, 16'h0034);
    chk_out("ior", 16'h1234, 1'b1, 1'b0, 1'b0);
    issue("ztest", 4'h7, 16'h0000, 16'h5555);
    chk_out("ztest", 16'h0000, 1'b1, 1'b1, 1'b0);

    // Back-pressure: result and flags hold, pending op not taken
    issue("stall_add", 4'h2, 16'h0010, 16'h0020);
    chk_out("stall_add", 16'h0030, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 4'h2;
    mem = 16'hFFFF;
    wreg = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_out("stall_hold", 16'h0030, 1'b0, 1'b0, 1'b0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    op = 4'h6;
    mem = 16'h00FF;
    wreg = 16'h0F0F;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("release_xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_result", 32'(result), 32'h0FF0);

    // Skip ops and NOP; flags set to C=1 Z=1 first so "held" is visible
    issue("pre_skip", 4'h3, 16'h8001, 16'h8001);
    chk_out("pre_skip", 16'h0000, 1'b1, 1'b1, 1'b0);
    issue("pcz_nz", 4'h8, 16'h0002, 16'h0000);
    chk_out("pcz_nz", 16'h0002, 1'b1, 1'b1, 1'b1);
    issue("pcz_z", 4'h8, 16'h0000, 16'h0000);
    chk_out("pcz_z", 16'h0000, 1'b1, 1'b1, 1'b0);
    issue("pczb_z", 4'h9, 16'h0000, 16'h0000);
    chk_out("pczb_z", 16'h0000, 1'b1, 1'b1, 1'b1);
    issue("nop", 4'hA, 16'h1111, 16'hC0DE);
    chk_out("nop", 16'hC0DE, 1'b1, 1'b1, 1'b0);
    issue("nop_f", 4'hF, 16'h1111, 16'hBEEF);
    chk_out("nop_f", 16'hBEEF, 1'b1, 1'b1, 1'b0);

`ifdef ALU_SEQ_MUL_EN
    // MUL 0x0100*0x0100 = 0x1_0000: low zero, upper nonzero
    issue("mul", 4'hD, 16'h0100, 16'h0100);
    for (int k = 2; k <= 17; k++) begin
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_valid_low", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    chk_out("mul", 16'h0000, 1'b1, 1'b1, 1'b0);
    chk("mul_busy_done", 32'(busy), 32'd0);

    issue("mul2", 4'hD, 16'h0003, 16'h0005);
    repeat (16) @(posedge clk);
    #1;
    chk_out("mul2", 16'h000F, 1'b0, 1'b0, 1'b0);

    // Abort a multiply with reset at busy cycle 5
    issue("mul_rst", 4'hD, 16'h0100, 16'h0100);
    repeat (4) @(posedge clk);
    #1;
    chk("mul_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mul_rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mul_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk_all_zero("mul_rst_after");
`else
    // Op D without the multiplier behaves as NOP
    chk("opd_busy_pre", 32'(busy), 32'd0);
    issue("opd_nop", 4'hD, 16'h0003, 16'h1234);
    chk_out("opd_nop", 16'h1234, 1'b1, 1'b1, 1'b0);
    chk("opd_busy_post", 32'(busy), 32'd0);

    // Asynchronous reset with a result held
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (>= 4).
REQ-002 SHALL have parameter SKIP_RESULT_MEM, default 1: result=mem for ops 8/9 when 1, result=0 when 0.
REQ-003 SHALL have one clock and an asynchronous active-low reset: port clk, input, 1 bit, rising-edge clock; port rst_n, input, 1 bit, async active-low reset.
REQ-004 SHALL have ports: in_valid input 1, operation offered; in_ready output 1, operation accepted when in_valid&&in_ready; op input 4, opcode; mem input WIDTH, operand A; wreg input WIDTH, operand B.
REQ-005 SHALL have ports: out_valid output 1, result held; out_ready input 1, consumer takes result; result output WIDTH; carry output 1; zero output 1; pc_skip output 1; busy output 1, multiply in progress.

Function
REQ-006 Opcodes SHALL be: 0 SHL, 1 SHR (logical), 2 ADD, 3 SUB, 4 AND, 5 IOR, 6 XOR, 7 ZTEST, 8 PCZ, 9 PCZB, A NOP, B ADDC, C SUBB, D MUL, E-F NOP.
REQ-007 SHL/SHR SHALL shift mem by one; carry = bit shifted out (msb for SHL, lsb for SHR); zero = (result==0).
REQ-008 ADD/ADDC SHALL compute mem+wreg(+carry for ADDC) mod 2^WIDTH; carry = carry out of bit WIDTH-1; zero = (result==0).
REQ-009 SUB/SUBB SHALL compute mem-wreg(-!carry for SUBB); carry = 1 when no borrow (unsigned mem >= subtrahend); zero = (result==0).
REQ-010 AND/IOR/XOR/ZTEST (ZTEST result = mem) SHALL update zero only; carry held.
REQ-011 PCZ SHALL set pc_skip = (mem!=0); PCZB SHALL set pc_skip = (mem==0); carry and zero held; pc_skip SHALL be 0 for every other op.
REQ-012 NOP SHALL give result = wreg, pc_skip = 0, carry and zero held.
REQ-013 ADDC/SUBB carry input SHALL be the carry register value at the accept cycle.
REQ-014 Single-cycle ops SHALL load result/carry/zero/pc_skip registers and set out_valid on the clock edge after acceptance (latency 1).
REQ-015 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready); back-to-back accept SHALL be possible every cycle under out_ready=1.
REQ-016 While out_valid && !out_ready, result, carry, zero, pc_skip SHALL hold stable; out_valid SHALL clear only on out_ready with no new completion.
REQ-017 State machine SHALL have states IDLE and MUL_BUSY: MUL accept IDLE->MUL_BUSY; after WIDTH shift-add iterations MUL_BUSY->IDLE with output load; busy = (state==MUL_BUSY).
REQ-018 MUL SHALL produce low WIDTH bits of unsigned mem*wreg; carry = (upper WIDTH bits != 0); zero = (low result==0); out_valid rises WIDTH+1 edges after accept.
REQ-019 Flags SHALL be status registers: they change only when a result is loaded, never on accept or stall.

Reset
REQ-020 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, carry 0, zero 0, pc_skip 0, busy 0, multiplier accumulator 0.
REQ-021 Reset during MUL_BUSY SHALL abort the multiply with no result produced; in_ready SHALL be 1 on the first edge after release.

Configuration
REQ-022 Macro ALU_SEQ_MUL_EN defined: MUL (op D) and MUL_BUSY state present per REQ-017/018.
REQ-023 Macro ALU_SEQ_MUL_EN undefined: op D SHALL behave as NOP, busy tied 0, state machine and multiplier removed.

Structure
REQ-024 Package alu_seq_pkg SHALL hold the opcode constants and the state typedef (IDLE, MUL_BUSY).
REQ-025 Sub-module alu_seq_mul SHALL implement the iterative shift-add multiplier (start, done, product 2*WIDTH), instantiated only under ALU_SEQ_MUL_EN.

Verification (WIDTH=16)
REQ-026 ADD mem=0x0001 wreg=0xFFFF -> next edge result 0x0000, C=1, Z=1, out_valid=1; then ADDC 0x0002+0x0003 -> 0x0006, C=0, Z=0.
REQ-027 SUB 0x8001-0x8001 -> 0x0000 C=1 Z=1; SUB 0x0001-0x0002 -> 0xFFFF C=0 Z=0; SUBB 0x0005-0x0001 -> 0x0003 C=1.
REQ-028 out_ready low 3 cycles after ADD result -> outputs stable, in_ready=0; out_ready high with new op -> accepted that cycle, next result one edge later.
REQ-029 PCZ mem=0x0002 -> pc_skip=1, flags unchanged; PCZB mem=0x0000 -> pc_skip=1; NOP wreg=0xC0DE -> result 0xC0DE, pc_skip=0.
REQ-030 MUL 0x0100*0x0100 -> result 0x0000, C=1, Z=1 at edge 17 after accept, busy=1 and in_ready=0 meanwhile; repeat with rst_n low at busy cycle 5 -> out_valid stays 0, all outputs 0.
REQ-031 Build without ALU_SEQ_MUL_EN: op D wreg=0x1234 -> result 0x1234 after one edge, busy=0 throughout.
